// File: rtl/one_hot.sv
// Registered one-hot to binary encoder: reports the lowest set bit of data_in
// and classifies the word as zero, single-hot (valid) or multi-hot.
module one_hot #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [(1<<N)-1:0]  data_in,
  output logic [N-1:0]       out,
  output logic               valid,
  output logic               zero,
  output logic               multi
);

  localparam int W = 1 << N;

  // seen[k]: some bit below k is set; many[k]: at least two bits below k are set.
  // Together they form the saturating 0/1/2+ bit count.
  logic [W:0]   seen;
  logic [W:0]   many;
  logic [W-1:0] first;
  logic [N-1:0] idx_next;
  logic         valid_next;
  logic         zero_next;
  logic         multi_next;

  assign seen[0] = 1'b0;
  assign many[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : gen_scan
      assign first[gi]  = data_in[gi] & ~seen[gi];
      assign seen[gi+1] = seen[gi] | data_in[gi];
      assign many[gi+1] = many[gi] | (seen[gi] & data_in[gi]);
    end
  endgenerate

  // first[] has at most one bit set, so OR-ing indices yields the lowest set bit.
  always_comb begin
    idx_next = '0;
    for (int i = 0; i < W; i++) begin
      if (first[i]) begin
        idx_next = idx_next | N'(i);
      end
    end
  end

  assign zero_next  = ~seen[W];
  assign multi_next = many[W];
  assign valid_next = seen[W] & ~many[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
      zero  <= 1'b0;
      multi <= 1'b0;
    end else begin
      out   <= idx_next;
      valid <= valid_next;
      zero  <= zero_next;
      multi <= multi_next;
    end
  end

endmodule

// File: tb/tb_one_hot.sv
// Self-checking bench for one_hot: N=4, N=2 and N=6 instances compared against
// a reference model built from $countones and a lowest-index search.
module tb_one_hot;

  logic        clk;
  logic        rst_n;
  logic [15:0] d4;
  logic [3:0]  d2;
  logic [63:0] d6;
  logic [3:0]  o4;
  logic [1:0]  o2;
  logic [5:0]  o6;
  logic        v4, z4, m4;
  logic        v2, z2, m2;
  logic        v6, z6, m6;

  int checks = 0;
  int errors = 0;

  one_hot #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4),
    .out(o4), .valid(v4), .zero(z4), .multi(m4)
  );

  one_hot #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(d2),
    .out(o2), .valid(v2), .zero(z2), .multi(m2)
  );

  one_hot #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(d6),
    .out(o6), .valid(v6), .zero(z6), .multi(m6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: lowest set index by forward search, class from the population count.
  task automatic check_inst(input string tag, input logic [63:0] d, input int w,
                            input logic [63:0] o, input logic v, input logic z,
                            input logic m);
    int idx;
    int ones;
    idx  = 0;
    ones = $countones(d);
    for (int i = 0; i < w; i++) begin
      if (d[i]) begin
        idx = i;
        break;
      end
    end
    chk($sformatf("%s out d=%h", tag, d), o, 64'(idx));
    chk($sformatf("%s valid d=%h", tag, d), 64'(v), 64'(ones == 1));
    chk($sformatf("%s zero d=%h", tag, d), 64'(z), 64'(ones == 0));
    chk($sformatf("%s multi d=%h", tag, d), 64'(m), 64'(ones >= 2));
    chk($sformatf("%s exclusive d=%h", tag, d), 64'($countones({v, z, m})), 64'd1);
  endtask

  // Drive on the falling edge, check just after the next rising edge (1-cycle latency).
  task automatic step(input logic [15:0] a, input logic [3:0] b, input logic [63:0] c);
    @(negedge clk);
    d4 = a;
    d2 = b;
    d6 = c;
    @(posedge clk);
    #1;
    check_inst("n4", {48'b0, a}, 16, {60'b0, o4}, v4, z4, m4);
    check_inst("n2", {60'b0, b}, 4, {62'b0, o2}, v2, z2, m2);
    check_inst("n6", c, 64, {58'b0, o6}, v6, z6, m6);
  endtask

  function automatic logic [63:0] rand_word(input int w);
    logic [63:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    case (mode)
      0: r = '0;
      1: r = 64'd1 << $urandom_range(0, w - 1);
      default: r = {$urandom, $urandom} & {$urandom, $urandom};
    endcase
    if (w < 64) r = r & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  initial begin
    logic [63:0] r16;
    logic [63:0] r4;
    logic [63:0] r64;

    rst_n = 1'b0;
    #12;
    chk("reset out", {60'b0, o4}, 64'd0);
    chk("reset valid", 64'(v4), 64'd0);
    chk("reset zero", 64'(z4), 64'd0);
    chk("reset multi", 64'(m4), 64'd0);
    #1;
    d4 = '0;
    d2 = '0;
    d6 = '0;
    #1;
    rst_n = 1'b1;

    // Directed one-hot sequence, back to back
    step(16'h0004, 4'h1, 64'h4);
    chk("dir out 0004", {60'b0, o4}, 64'd2);
    step(16'h0010, 4'h2, 64'h10);
    chk("dir out 0010", {60'b0, o4}, 64'd4);
    step(16'h0002, 4'h4, 64'h2);
    chk("dir out 0002", {60'b0, o4}, 64'd1);

    // Extremes
    step(16'h0001, 4'h1, 64'h1);
    chk("ext out 0001", {60'b0, o4}, 64'd0);
    step(16'h8000, 4'h8, 64'h8000_0000_0000_0000);
    chk("ext out 8000", {60'b0, o4}, 64'd15);
    chk("ext out n6 msb", {58'b0, o6}, 64'd63);

    // Zero and multi-hot
    step(16'h0000, 4'h0, 64'h0);
    chk("zero flag", 64'(z4), 64'd1);
    step(16'h0014, 4'h6, 64'h14);
    chk("multi out 0014", {60'b0, o4}, 64'd2);
    chk("multi flag 0014", 64'(m4), 64'd1);
    step(16'hFFFF, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("multi out FFFF", {60'b0, o4}, 64'd0);

    // Asynchronous reset mid-run with out = 4
    step(16'h0010, 4'h2, 64'h10);
    chk("pre-reset out", {60'b0, o4}, 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out", {60'b0, o4}, 64'd0);
    chk("async reset valid", 64'(v4), 64'd0);
    chk("async reset out n6", {58'b0, o6}, 64'd0);
    #2;
    rst_n = 1'b1;

    // Exhaustive single-bit sweep across all three widths
    for (int i = 0; i < 64; i++) begin
      step(16'd1 << (i % 16), 4'd1 << (i % 4), 64'd1 << i);
    end

    // Randomized mix of zero, single-hot and multi-hot words
    for (int k = 0; k < 300; k++) begin
      r16 = rand_word(16);
      r4  = rand_word(4);
      r64 = rand_word(64);
      step(r16[15:0], r4[3:0], r64);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
